// File: rtl/flappy_pkg.sv
// Shared types and defaults for the flap-button input path.
package flappy_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    ARM_PRESS   = 2'd1,
    HELD        = 2'd2,
    ARM_RELEASE = 2'd3
  } btn_state_t;

  localparam int DEBOUNCE_10MS_25M = 250000;
  localparam int REPEAT_OFF        = 0;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/flap_button_conditioner_sync2.sv
// Two-flop synchroniser for asynchronous inputs; RST_VAL sets the idle level held in reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_s1;
  logic r_s2;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;

endmodule

// File: rtl/flap_button_conditioner.sv
// Synchronises and debounces the active-low flap button, producing flap/release strobes,
// optional hold-to-repeat flaps, a debounced level and a press counter.
module flap_button_conditioner
  import flappy_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_25M,
  parameter int REPEAT_DELAY    = REPEAT_OFF,
  parameter int REPEAT_PERIOD   = 6250000,
  parameter int CNT_W           = 8
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             btn_n,
  input  logic             enable,
  output logic             flap_pulse,
  output logic             release_pulse,
  output logic             btn_held,
  output logic [CNT_W-1:0] press_count,
  output logic [1:0]       dbg_state
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES);
  localparam int RPT_MAX = max2(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int RPT_W   = (RPT_MAX > 0) ? $clog2(RPT_MAX + 1) : 1;
  localparam bit RPT_EN  = (REPEAT_DELAY > 0);

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [RPT_W-1:0] RPT_FIRST = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_NEXT  = RPT_W'(REPEAT_PERIOD - 1);

  logic w_sync_q;
  logic w_s;

  btn_state_t       r_state, w_state_nx;
  logic [DB_W-1:0]  r_db_cnt, w_db_cnt_nx;
  logic [RPT_W-1:0] r_rpt_cnt, w_rpt_cnt_nx;
  logic             r_rpt_armed, w_rpt_armed_nx;
  logic             r_flap, w_flap_nx;
  logic             r_release, w_release_nx;
  logic             r_held, w_held_nx;
  logic [CNT_W-1:0] r_count, w_count_nx;
  logic             w_rpt_step;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .i_clk (clkin),
    .i_rst (rst),
    .i_d   (btn_n),
    .o_q   (w_sync_q)
  );

  assign w_s = ~w_sync_q;

  // A pressed sample while debounced-high counts toward the repeat timer, including the
  // sample that bounces ARM_RELEASE back to HELD, so held time is measured in pressed cycles.
  assign w_rpt_step = w_s && ((r_state == HELD) || (r_state == ARM_RELEASE));

  always_ff @(posedge clkin) begin
    if (rst) begin
      r_state     <= IDLE;
      r_db_cnt    <= '0;
      r_rpt_cnt   <= '0;
      r_rpt_armed <= 1'b0;
      r_flap      <= 1'b0;
      r_release   <= 1'b0;
      r_held      <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_db_cnt    <= w_db_cnt_nx;
      r_rpt_cnt   <= w_rpt_cnt_nx;
      r_rpt_armed <= w_rpt_armed_nx;
      r_flap      <= w_flap_nx;
      r_release   <= w_release_nx;
      r_held      <= w_held_nx;
      r_count     <= w_count_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_db_cnt_nx    = r_db_cnt;
    w_rpt_cnt_nx   = r_rpt_cnt;
    w_rpt_armed_nx = r_rpt_armed;
    w_flap_nx      = 1'b0;
    w_release_nx   = 1'b0;
    w_held_nx      = r_held;
    w_count_nx     = r_count;

    case (r_state)
      IDLE: begin
        if (w_s) begin
          w_state_nx  = ARM_PRESS;
          w_db_cnt_nx = DB_W'(1);
        end
      end
      ARM_PRESS: begin
        if (!w_s) begin
          w_state_nx  = IDLE;
          w_db_cnt_nx = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nx     = HELD;
          w_held_nx      = 1'b1;
          w_db_cnt_nx    = '0;
          w_rpt_cnt_nx   = '0;
          w_rpt_armed_nx = 1'b0;
          if (enable) begin
            w_flap_nx  = 1'b1;
            w_count_nx = r_count + CNT_W'(1);
          end
        end else begin
          w_db_cnt_nx = r_db_cnt + DB_W'(1);
        end
      end
      HELD: begin
        if (!w_s) begin
          w_state_nx  = ARM_RELEASE;
          w_db_cnt_nx = DB_W'(1);
        end
      end
      ARM_RELEASE: begin
        if (w_s) begin
          w_state_nx  = HELD;
          w_db_cnt_nx = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state_nx   = IDLE;
          w_held_nx    = 1'b0;
          w_release_nx = 1'b1;
          w_db_cnt_nx  = '0;
        end else begin
          w_db_cnt_nx = r_db_cnt + DB_W'(1);
        end
      end
      default: w_state_nx = IDLE;
    endcase

    if (RPT_EN && w_rpt_step) begin
      if (r_rpt_cnt == (r_rpt_armed ? RPT_NEXT : RPT_FIRST)) begin
        w_rpt_cnt_nx   = '0;
        w_rpt_armed_nx = 1'b1;
        w_flap_nx      = enable;
      end else begin
        w_rpt_cnt_nx = r_rpt_cnt + RPT_W'(1);
      end
    end
  end

  assign flap_pulse    = r_flap;
  assign release_pulse = r_release;
  assign btn_held      = r_held;
  assign press_count   = r_count;
  assign dbg_state     = r_state;

endmodule

// File: tb/tb_flap_button_conditioner.sv
// Bench for flap_button_conditioner: two instances (repeat off / repeat on) share stimulus
// and are checked every cycle against a run-length reference model.
module tb_flap_button_conditioner;
  import flappy_pkg::*;

  localparam int D = 4;
  localparam int RDA [2] = '{0, 10};
  localparam int RPA [2] = '{5, 5};

  logic       clk = 1'b0;
  logic       rst;
  logic       btn_n;
  logic       enable;
  logic       flap [2];
  logic       rel  [2];
  logic       held [2];
  logic [7:0] cnt  [2];
  logic [1:0] st   [2];

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  flap_button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(0), .REPEAT_PERIOD(5), .CNT_W(8)) u_dut0 (
    .clkin(clk), .rst(rst), .btn_n(btn_n), .enable(enable),
    .flap_pulse(flap[0]), .release_pulse(rel[0]), .btn_held(held[0]),
    .press_count(cnt[0]), .dbg_state(st[0])
  );

  flap_button_conditioner #(.DEBOUNCE_CYCLES(D), .REPEAT_DELAY(10), .REPEAT_PERIOD(5), .CNT_W(8)) u_dut1 (
    .clkin(clk), .rst(rst), .btn_n(btn_n), .enable(enable),
    .flap_pulse(flap[1]), .release_pulse(rel[1]), .btn_held(held[1]),
    .press_count(cnt[1]), .dbg_state(st[1])
  );

  // Reference model: raw input delayed two samples, then a run-length rule on the
  // synchronised level; repeat flaps derive from the count of pressed samples since the press.
  logic       m_p1, m_p2, m_sprev;
  int         m_run;
  logic       m_level [2];
  int         m_steps [2];
  logic [7:0] m_cnt   [2];
  logic       e_flap  [2];
  logic       e_rel   [2];
  btn_state_t e_st    [2];

  always @(posedge clk) begin
    logic s;
    if (rst) begin
      m_p1 = 1'b1; m_p2 = 1'b1; m_sprev = 1'b0; m_run = 0;
      for (int i = 0; i < 2; i++) begin
        m_level[i] = 1'b0; m_steps[i] = 0; m_cnt[i] = 8'd0;
        e_flap[i] = 1'b0; e_rel[i] = 1'b0; e_st[i] = IDLE;
      end
    end else begin
      s = ~m_p2;
      m_p2 = m_p1;
      m_p1 = btn_n;
      m_run = (s == m_sprev) ? m_run + 1 : 1;
      m_sprev = s;
      for (int i = 0; i < 2; i++) begin
        e_flap[i] = 1'b0;
        e_rel[i]  = 1'b0;
        if (!m_level[i]) begin
          if (s && m_run >= D) begin
            m_level[i] = 1'b1;
            m_steps[i] = 0;
            e_st[i] = HELD;
            if (enable) begin
              e_flap[i] = 1'b1;
              m_cnt[i] = m_cnt[i] + 8'd1;
            end
          end else begin
            e_st[i] = s ? ARM_PRESS : IDLE;
          end
        end else begin
          if (!s && m_run >= D) begin
            m_level[i] = 1'b0;
            e_rel[i] = 1'b1;
            e_st[i] = IDLE;
          end else if (s) begin
            m_steps[i]++;
            e_st[i] = HELD;
            if (RDA[i] > 0 && enable &&
                (m_steps[i] == RDA[i] ||
                 (m_steps[i] > RDA[i] && (m_steps[i] - RDA[i]) % RPA[i] == 0)))
              e_flap[i] = 1'b1;
          end else begin
            e_st[i] = ARM_RELEASE;
          end
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("flap%0d", i), flap[i], e_flap[i]);
        check($sformatf("rel%0d", i), rel[i], e_rel[i]);
        check($sformatf("held%0d", i), held[i], m_level[i]);
        check($sformatf("cnt%0d", i), cnt[i], m_cnt[i]);
        check($sformatf("state%0d", i), st[i], e_st[i]);
        check($sformatf("excl%0d", i), flap[i] & rel[i], 1'b0);
      end
    end
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_cycles(2);
    rst = 1'b0;
  endtask

  logic [31:0] exp_q[$];

  initial begin
    int first, nflap, nrel, base1, start;
    rst = 1'b1; btn_n = 1'b1; enable = 1'b1;
    idle_cycles(3);
    cmp_on = 1'b1;
    check("reset_held", held[0], 1'b0);
    check("reset_cnt", cnt[0], 8'd0);
    check("reset_state", st[0], IDLE);
    rst = 1'b0;
    idle_cycles(3);

    // Press latency: flap on the 6th cycle after the first low sample.
    btn_n = 1'b0; first = -1; nflap = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (flap[0]) begin nflap++; if (first < 0) first = n; end
    end
    check("t1_flap_cycle", first, 6);
    check("t1_flap_count", nflap, 1);
    check("t1_held", held[0], 1'b1);
    check("t1_cnt", cnt[0], 8'd1);
    btn_n = 1'b1; idle_cycles(12);

    // Bounces shorter than the debounce window are ignored.
    nflap = 0;
    btn_n = 1'b0; for (int n = 0; n < 3; n++) begin @(negedge clk); nflap += flap[0]; end
    btn_n = 1'b1; for (int n = 0; n < 2; n++) begin @(negedge clk); nflap += flap[0]; end
    btn_n = 1'b0; for (int n = 0; n < 3; n++) begin @(negedge clk); nflap += flap[0]; end
    btn_n = 1'b1; for (int n = 0; n < 10; n++) begin @(negedge clk); nflap += flap[0]; end
    check("t2_flaps", nflap, 0);
    check("t2_held", held[0], 1'b0);
    check("t2_cnt", cnt[0], 8'd1);

    // Release bounce keeps the button held; clean release strobes after 6 cycles.
    btn_n = 1'b0; idle_cycles(10);
    nrel = 0;
    btn_n = 1'b1; for (int n = 0; n < 2; n++) begin @(negedge clk); nrel += rel[0]; end
    btn_n = 1'b0; for (int n = 0; n < 5; n++) begin @(negedge clk); nrel += rel[0]; end
    check("t3_held_mid", held[0], 1'b1);
    btn_n = 1'b1; first = -1;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (rel[0]) begin nrel++; if (first < 0) first = n; end
    end
    check("t3_rel_cycle", first, 6);
    check("t3_rel_count", nrel, 1);
    check("t3_held_end", held[0], 1'b0);

    // Hold-to-repeat on the repeating instance.
    exp_q = '{0, 10, 15, 20, 25, 30};
    base1 = int'(cnt[1]); start = -1; nflap = 0;
    btn_n = 1'b0;
    for (int n = 1; n <= 50; n++) begin
      if (n == 39) btn_n = 1'b1;
      @(negedge clk);
      if (flap[1]) begin
        if (start < 0) start = n;
        if (exp_q.size() > 0) check("t4_rpt_offset", n - start, exp_q.pop_front());
        else check("t4_extra_flap", n - start, 0);
        nflap++;
      end
    end
    check("t4_flap_total", nflap, 6);
    check("t4_cnt_delta", int'(cnt[1]) - base1, 1);

    // Disabled: debounce and release still run, no flaps or counts.
    enable = 1'b0; base1 = int'(cnt[0]); nflap = 0; nrel = 0;
    btn_n = 1'b0; for (int n = 0; n < 10; n++) begin @(negedge clk); nflap += flap[0]; end
    check("t5_held", held[0], 1'b1);
    btn_n = 1'b1; for (int n = 0; n < 12; n++) begin @(negedge clk); nflap += flap[0]; nrel += rel[0]; end
    check("t5_flaps", nflap, 0);
    check("t5_rel", nrel, 1);
    check("t5_cnt", int'(cnt[0]), base1);
    enable = 1'b1;

    // Random bouncing, enable toggling and occasional resets.
    for (int k = 0; k < 300; k++) begin
      btn_n  = 1'($urandom_range(0, 1));
      enable = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) rst = 1'b1;
      if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(10, 45));
      else idle_cycles($urandom_range(1, 6));
      rst = 1'b0;
    end
    btn_n = 1'b1; enable = 1'b1; idle_cycles(12);

    // Counter wrap, then reset while held.
    do_reset();
    for (int k = 0; k < 255; k++) begin
      btn_n = 1'b0; idle_cycles(6);
      btn_n = 1'b1; idle_cycles(6);
    end
    check("t6_cnt_255", cnt[0], 8'd255);
    btn_n = 1'b0; idle_cycles(6);
    btn_n = 1'b1; idle_cycles(6);
    check("t6_cnt_wrap", cnt[0], 8'd0);
    btn_n = 1'b0; idle_cycles(8);
    check("t6_held_pre", held[0], 1'b1);
    rst = 1'b1; @(negedge clk);
    check("t6_rst_held", held[0], 1'b0);
    check("t6_rst_flap", flap[0], 1'b0);
    check("t6_rst_rel", rel[0], 1'b0);
    check("t6_rst_state", st[0], IDLE);
    rst = 1'b0; idle_cycles(10);
    btn_n = 1'b1; idle_cycles(12);

    cmp_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/flap_button_conditioner.md
Name: flap_button_conditioner

Overview:
- Upstream conditioning stage for the flap push-button, ahead of the game core.
- Takes the raw, bouncy, asynchronous active-low button and synchronises and debounces it.
- Produces single-cycle flap pulses, with optional hold-to-repeat, plus a debounced level and a press counter.
- Replaces direct edge-clocking on the raw button: the game core samples flap_pulse on its one system clock.

Parameters:
DEBOUNCE_CYCLES, 250000, consecutive stable sync'd samples needed to accept a level change (10 ms at 25 MHz); legal range 2..2^24-1.
REPEAT_DELAY, 0, cycles held after accepted press before first auto-repeat flap; 0 disables repeat.
REPEAT_PERIOD, 6250000, cycles between auto-repeat flaps after the first; legal range >=1 when repeat is enabled.
CNT_W, 8, width of press_count.

Ports:
clkin  input  1  system clock (25 MHz pixel clock domain).
rst  input  1  synchronous, active-high reset.
btn_n  input  1  raw button, asynchronous, active-low (0 = pressed).
enable  input  1  1 = flap pulses allowed; 0 (e.g. game over) suppresses flap_pulse and count only.
flap_pulse  output  1  one-cycle strobe per accepted press and per auto-repeat.
release_pulse  output  1  one-cycle strobe per accepted release.
btn_held  output  1  debounced level, 1 = pressed.
press_count  output  CNT_W  accepted, enabled presses; wraps modulo 2^CNT_W.

Behaviour:
- Reset: one clock and one reset. Reset is synchronous, active-high, named rst; clock is clkin.
- Reset values: state=IDLE, all counters 0, flap_pulse=0, release_pulse=0, btn_held=0, press_count=0. Sync flops reset to 1 (released).
- Synchroniser: 2-flop chain on btn_n. `s` is the second-flop output, inverted to active-high.
- FSM states: IDLE, ARM_PRESS, HELD, ARM_RELEASE.
- IDLE: when s=1, go to ARM_PRESS with db_cnt=1.
- ARM_PRESS:
  - s=1 and db_cnt==DEBOUNCE_CYCLES-1: go to HELD, btn_held<=1.
  - If enable=1: flap_pulse<=1 and press_count increments.
  - Clear rpt_cnt.
  - s=1 otherwise: db_cnt increments.
  - s=0: return to IDLE, db_cnt=0, no outputs.
- HELD:
  - s=0: go to ARM_RELEASE with db_cnt=1.
  - Else, if REPEAT_DELAY>0:
    - rpt_cnt counts up.
    - First repeat fires when rpt_cnt reaches REPEAT_DELAY-1 (exactly REPEAT_DELAY cycles after the press pulse).
    - Subsequent repeats fire every REPEAT_PERIOD cycles.
    - Each repeat pulses flap_pulse only if enable=1; repeats do not increment press_count.
- ARM_RELEASE:
  - s=0 for DEBOUNCE_CYCLES consecutive cycles: go to IDLE, btn_held<=0, release_pulse<=1.
  - s=1 before that: back to HELD, rpt_cnt resumes (not cleared).
- Latency: raw press sampled at edge k gives flap_pulse high in the cycle after edge k+1+DEBOUNCE_CYCLES, i.e. 2 sync + DEBOUNCE_CYCLES cycles. Release uses the same latency.
- Pulses are registered and exactly one cycle wide. flap_pulse and release_pulse are never high together.
- enable gates only flap_pulse and press_count; debouncing and btn_held run regardless. Raising enable mid-hold emits nothing until the next repeat slot or next press.
- Counter widths: db_cnt is clog2(DEBOUNCE_CYCLES) bits; rpt_cnt is clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1) bits. No overflow is possible since both are compared and cleared.
- rst asserted mid-debounce or mid-hold: next cycle all outputs are at reset values, with no release_pulse emitted.
- press_count at 2^CNT_W-1 plus one press gives 0.

Decomposition:
- Package flappy_pkg: btn_state_t enum (IDLE, ARM_PRESS, HELD, ARM_RELEASE), default constants DEBOUNCE_10MS_25M=250000, REPEAT_OFF=0.
- One sub-module: sync2, a 2-flop synchroniser with a reset-value parameter, reused later for other async inputs.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=0 unless noted):
1. Reset, then btn_n held low 20 cycles with enable=1 -> flap_pulse single cycle at cycle 6 after first low sample; btn_held=1 from same cycle; press_count=1.
2. btn_n glitches low 3 cycles, high 2, low 3, then high -> no flap_pulse; btn_held stays 0; press_count=0.
3. Press accepted, then btn_n high 2 cycles, low again -> no release_pulse; btn_held stays 1. Then high 10 cycles -> release_pulse exactly once, 6 cycles after the last low-to-high; btn_held=0.
4. REPEAT_DELAY=10, REPEAT_PERIOD=5, hold 40 cycles -> flap pulses at press cycle P, P+10, P+15, P+20, P+25, P+30; press_count=1.
5. enable=0 during full press and release -> btn_held and release_pulse behave normally; flap_pulse never asserts; press_count=0.
6. Preload 255 presses (CNT_W=8), one more press -> press_count=0. Then assert rst during HELD -> next cycle btn_held=0, no pulses, state IDLE.
